io_event_ctrl: RTL and testbench

IO_EVENT_CTRL -- requirements
Module: io_event_ctrl

---
 rtl/io_event_ctrl.sv | 156 +++++++++++++++
 tb/tb_io_event_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/io_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_event_ctrl
// Brief    : Debounced button events queued in a small FIFO plus an LED
//            register. Optional IO_OVERFLOW_FLAG_EN adds a sticky overflow
//            bit on rdata[31].
// Revision : 1.0  initial release
// ============================================================================
module io_event_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          FIFO_DEPTH      = 4,
  parameter logic [31:0] IO_READ_ADDR    = 32'd4096,
  parameter logic [31:0] LED_ADDR        = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  btn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wren,
  input  logic        rd_en,
  output logic        io_hit,
  output logic [31:0] rdata,
  output logic [15:0] led
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    btn_meta;
  logic [3:0]    btn_sync;
  logic [3:0]    deb;
  logic [CW-1:0] cnt [4];
  logic [3:0]    settle;
  logic [3:0]    rise;
  logic [3:0]    pending;
  logic [3:0]    clr;
  logic          push_any;
  logic [1:0]    push_idx;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic [2:0]    mem [FIFO_DEPTH];
  logic          ovf_bit;
  logic          unused_ok;

  assign unused_ok = ^wdata[31:16];

  // Synchronizers and per-button debounce counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      deb      <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
      for (int i = 0; i < 4; i++) begin
        if (btn_sync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (settle[i]) begin
          cnt[i] <= '0;
          deb[i] <= btn_sync[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    settle = '0;
    for (int i = 0; i < 4; i++) begin
      settle[i] = (btn_sync[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end
    rise = settle & btn_sync;
  end

  // Lowest index wins: U(0) > D(1) > L(2) > R(3)
  always_comb begin
    push_any = 1'b0;
    push_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        push_any = 1'b1;
        push_idx = 2'(i);
      end
    end
  end

  assign io_hit = (addr == IO_READ_ADDR);
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop    = rd_en && io_hit && !empty;
  assign push   = push_any && (!full || pop);

  always_comb begin
    clr = '0;
    if (push) clr[push_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      wptr    <= '0;
      rptr    <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define valid contents
  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= {1'b0, push_idx} + 3'd1;
  end

`ifdef IO_OVERFLOW_FLAG_EN
  logic [3:0] drop;
  logic       ovf;

  assign drop = rise & pending & ~clr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (|drop) begin
      ovf <= 1'b1;
    end else if (rd_en && io_hit) begin
      ovf <= 1'b0;
    end
  end

  assign ovf_bit = ovf;
`else
  assign ovf_bit = 1'b0;
`endif

  assign rdata = {ovf_bit, 28'd0, empty ? 3'd0 : mem[rptr[AW-1:0]]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led <= '0;
    end else if (wren && (addr == LED_ADDR)) begin
      led <= wdata[15:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_event_ctrl
// Brief    : Directed self-checking bench for io_event_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_event_ctrl;

  logic        clock;
  logic        reset;
  logic [3:0]  btn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wren;
  logic        rd_en;
  logic        io_hit;
  logic [31:0] rdata;
  logic [15:0] led;

  int errors;
  int checks;
  logic ovf_exp;

  io_event_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4),
    .IO_READ_ADDR   (32'd4096),
    .LED_ADDR       (32'd1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .btn   (btn),
    .addr  (addr),
    .wdata (wdata),
    .wren  (wren),
    .rd_en (rd_en),
    .io_hit(io_hit),
    .rdata (rdata),
    .led   (led)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    tick(10);
    btn = 4'b0;
    tick(10);
  endtask

  task automatic pop_one;
    addr  = 32'd4096;
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
`ifdef IO_OVERFLOW_FLAG_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    errors = 0;
    checks = 0;
    clock  = 1'b0;
    reset  = 1'b0;
    btn    = 4'b0;
    addr   = 32'd0;
    wdata  = 32'd0;
    wren   = 1'b0;
    rd_en  = 1'b0;
    tick(2);
    check("reset_rdata", rdata, 32'd0);
    check("reset_led", {16'd0, led}, 32'd0);
    check("io_hit_miss", {31'd0, io_hit}, 32'd0);
    addr = 32'd4096;
    #1;
    check("io_hit_hit", {31'd0, io_hit}, 32'd1);
    reset = 1'b1;
    tick(2);

    // Pop on empty FIFO has no effect
    pop_one();
    check("empty_pop", rdata, 32'd0);

    // Single U press
    press(4'b0001);
    check("u_event", rdata, 32'd1);
    pop_one();
    check("u_popped", rdata, 32'd0);

    // Bouncing D never settles
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(2);
    end
    btn = 4'b0;
    tick(10);
    check("bounce_none", rdata, 32'd0);

    // U and R settle together: U first
    press(4'b1001);
    check("ur_first", rdata, 32'd1);
    pop_one();
    check("ur_second", rdata, 32'd4);
    pop_one();
    check("ur_empty", rdata, 32'd0);

    // Six presses with no reads: 4 queued, 1 held pending, 1 dropped
    press(4'b1111);
    check("fill_head", rdata, 32'd1);
    press(4'b0001);
    check("full_head", rdata, 32'd1);
    press(4'b0001);
    check("ovf_set", rdata, {ovf_exp, 28'd0, 3'd1});
    pop_one();
    check("ovf_clear_head_d", rdata, 32'd2);
    pop_one();
    check("head_l", rdata, 32'd3);
    pop_one();
    check("head_r", rdata, 32'd4);
    pop_one();
    check("held_u", rdata, 32'd1);
    pop_one();
    check("drained", rdata, 32'd0);

    // LED register
    addr  = 32'd1;
    wdata = 32'hABCD1234;
    wren  = 1'b1;
    tick(1);
    wren = 1'b0;
    check("led_write", {16'd0, led}, 32'h0000_1234);
    addr  = 32'd4096;
    wdata = 32'h0000_5555;
    wren  = 1'b1;
    tick(1);
    check("led_ignore_io", {16'd0, led}, 32'h0000_1234);
    addr = 32'd2;
    tick(1);
    wren = 1'b0;
    check("led_ignore_other", {16'd0, led}, 32'h0000_1234);

    // Reset mid-queue with U held through reset
    press(4'b0010);
    check("pre_reset_head", rdata, 32'd2);
    btn   = 4'b0001;
    reset = 1'b0;
    #2;
    check("reset_async_led", {16'd0, led}, 32'd0);
    check("reset_async_rdata", rdata, 32'd0);
    tick(2);
    reset = 1'b1;
    tick(3);
    check("held_not_yet", rdata, 32'd0);
    tick(10);
    check("held_after_deb", rdata, 32'd1);
    btn = 4'b0;
    tick(10);
    pop_one();
    check("final_empty", rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
